clk_div_prog: RTL and testbench

Runtime-programmable clock divider and tick generator. It is the successor to the fixed-limit divider used for the 12 MHz board clock.
- Divisor width and reset divisor are parameters.
- The divisor can be reloaded at runtime through a shadow register. The new value takes effect only on a period boundary.
- Provides a 50%-duty toggle output and a one-cycle tick (strobe), plus enable and synchronous phase restart.
- Feeds UART baud/bit timing and slow LED/sample clocks from clk_in.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_prog.sv | 118 +++++++++++
 tb/tb_clk_div_prog.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//   DIV_*_TICK : divisors giving common tick rates from a 12 MHz clock.
//   div_for()  : divisor for a wanted tick rate, i.e. f_clk/f_tick - 1.
//                The counter runs 0..N, so a divisor of N gives N+1 cycles per tick.
package clk_div_pkg;

  localparam int unsigned DIV_100HZ_TICK  = 32'd119999;
  localparam int unsigned DIV_9600_TICK   = 32'd1249;
  localparam int unsigned DIV_115200_TICK = 32'd103;

  function automatic int unsigned div_for(input int unsigned f_clk,
                                          input int unsigned f_tick);
    return (f_clk / f_tick) - 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider and tick generator.
//   clk_in   : system clock, all logic on its rising edge
//   rst      : asynchronous active-high reset
//   en       : count enable; low freezes the count and clk_out
//   sync_clr : synchronous phase restart (count, clk_out and tick go to 0)
//   div_in   : new divisor value
//   div_load : one-cycle strobe that captures div_in
//   clk_out  : 50%-duty toggle output, f_clk / (2*(N+1))
//   tick     : one-cycle strobe, once every N+1 cycles
//   cur_div  : divisor currently in use
//   pending  : a loaded divisor is waiting for the next period boundary
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned       WIDTH       = 17,
  parameter logic [WIDTH-1:0]  DEFAULT_DIV = 17'd120000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div,
  output logic             pending
);

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q,      count_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] div_shadow_q, div_shadow_d;
  logic             pend_q,       pend_d;
  logic             clk_out_q,    clk_out_d;
  logic             tick_q,       tick_d;
  logic             term_s;
  logic             boundary_s;

  // Next-state logic for the counter, outputs and the divisor shadow.
  always_comb begin
    count_d      = count_q;
    div_active_d = div_active_q;
    div_shadow_d = div_shadow_q;
    pend_d       = pend_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;

    // >= rather than == so a divisor shrinking below the count ends the
    // period at once instead of wrapping through the full counter range.
    term_s = en & (count_q >= div_active_q);

    // Any cycle where the period is not running normally is a safe point to
    // swap divisors: a phase restart, a frozen counter or a terminal count.
    boundary_s = sync_clr | ~en | term_s;

    if (sync_clr) begin
      count_d   = CNT_ZERO;
      clk_out_d = 1'b0;
    end else if (term_s) begin
      count_d   = CNT_ZERO;
      clk_out_d = ~clk_out_q;
      tick_d    = 1'b1;
    end else if (en) begin
      count_d   = count_q + CNT_ONE;
    end else begin
      count_d   = count_q;
    end

    // A load landing on a boundary goes straight to the active divisor;
    // otherwise it is parked in the shadow (last load wins) until one comes.
    if (boundary_s) begin
      if (div_load) begin
        div_active_d = div_in;
        pend_d       = 1'b0;
      end else if (pend_q) begin
        div_active_d = div_shadow_q;
        pend_d       = 1'b0;
      end else begin
        div_active_d = div_active_q;
      end
    end else begin
      if (div_load) begin
        div_shadow_d = div_in;
        pend_d       = 1'b1;
      end else begin
        div_shadow_d = div_shadow_q;
      end
    end
  end

  // State registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count_q      <= CNT_ZERO;
      div_active_q <= DEFAULT_DIV;
      div_shadow_q <= DEFAULT_DIV;
      pend_q       <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      div_active_q <= div_active_d;
      div_shadow_q <= div_shadow_d;
      pend_q       <= pend_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign cur_div = div_active_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog with WIDTH=8, DEFAULT_DIV=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clk_div_prog;

  localparam int unsigned W = 8;

  logic         clk_in;
  logic         rst;
  logic         en;
  logic         sync_clr;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] cur_div;
  logic         pending;

  int checks;
  int errors;

  clk_div_prog #(
    .WIDTH       (W),
    .DEFAULT_DIV (8'd3)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .div_in   (div_in),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .cur_div  (cur_div),
    .pending  (pending)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk_in);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    sync_clr = 1'b0;
    div_in   = 8'd0;
    div_load = 1'b0;

    // Reset state
    #1;
    check_eq("rst_clk_out", 32'(clk_out), 32'd0);
    check_eq("rst_tick",    32'(tick),    32'd0);
    check_eq("rst_cur_div", 32'(cur_div), 32'd3);
    check_eq("rst_pending", 32'(pending), 32'd0);
    cyc();
    rst = 1'b0;
    en  = 1'b1;

    // 1. Free run: tick on every 4th edge, clk_out toggles with each tick
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check_eq("s1_tick",    32'(tick),    ((i % 4) == 0) ? 32'd1 : 32'd0);
      check_eq("s1_clk_out", 32'(clk_out), (i >= 4 && i < 8) ? 32'd1 : 32'd0);
    end
    check_eq("s1_cur_div", 32'(cur_div), 32'd3);

    // 2. Runtime load of 1 mid-period (count=1 when the load lands)
    cyc();
    check_eq("s2_tick_a", 32'(tick), 32'd0);
    div_in   = 8'd1;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check_eq("s2_pend_a", 32'(pending), 32'd1);
    check_eq("s2_cur_a",  32'(cur_div), 32'd3);
    check_eq("s2_tick_b", 32'(tick),    32'd0);
    cyc();
    check_eq("s2_pend_b", 32'(pending), 32'd1);
    check_eq("s2_tick_c", 32'(tick),    32'd0);
    cyc();
    check_eq("s2_tick_d", 32'(tick),    32'd1);
    check_eq("s2_cur_b",  32'(cur_div), 32'd1);
    check_eq("s2_pend_c", 32'(pending), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_eq("s2_tick2", 32'(tick), ((i % 2) == 0) ? 32'd1 : 32'd0);
    end
    check_eq("s2_clk_out", 32'(clk_out), 32'd1);

    // 3a. Load 5 on the terminal cycle: applied at once, no pending
    cyc();
    check_eq("s3_tick_a", 32'(tick), 32'd0);
    div_in   = 8'd5;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check_eq("s3_tick_b", 32'(tick),    32'd1);
    check_eq("s3_cur_a",  32'(cur_div), 32'd5);
    check_eq("s3_pend_a", 32'(pending), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check_eq("s3_tick6", 32'(tick), (i == 6) ? 32'd1 : 32'd0);
    end
    check_eq("s3_clk_out", 32'(clk_out), 32'd1);

    // 3b. Two loads (7 then 2) before the boundary: last one wins
    div_in   = 8'd7;
    div_load = 1'b1;
    cyc();
    div_in   = 8'd2;
    cyc();
    div_load = 1'b0;
    check_eq("s3_pend_b", 32'(pending), 32'd1);
    check_eq("s3_cur_b",  32'(cur_div), 32'd5);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check_eq("s3_tick_wait", 32'(tick), 32'd0);
    end
    cyc();
    check_eq("s3_tick_c", 32'(tick),    32'd1);
    check_eq("s3_cur_c",  32'(cur_div), 32'd2);
    check_eq("s3_pend_c", 32'(pending), 32'd0);

    // 4. Shrink below count: div=7, count=6 frozen, load 2
    en       = 1'b0;
    div_in   = 8'd7;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    en       = 1'b1;
    check_eq("s4_cur_a",  32'(cur_div), 32'd7);
    check_eq("s4_pend_a", 32'(pending), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check_eq("s4_count_up", 32'(tick), 32'd0);
    end
    en       = 1'b0;
    div_in   = 8'd2;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check_eq("s4_cur_b",  32'(cur_div), 32'd2);
    check_eq("s4_pend_b", 32'(pending), 32'd0);
    check_eq("s4_tick_a", 32'(tick),    32'd0);
    en = 1'b1;
    cyc();
    check_eq("s4_tick_b",    32'(tick),    32'd1);
    check_eq("s4_clk_out_a", 32'(clk_out), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check_eq("s4_tick3", 32'(tick), (i == 3) ? 32'd1 : 32'd0);
    end
    check_eq("s4_clk_out_b", 32'(clk_out), 32'd0);

    // 5a. Freeze with en=0 for 10 cycles at count=1 (divisor back to 3)
    cyc();
    en       = 1'b0;
    div_in   = 8'd3;
    div_load = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      div_load = 1'b0;
      check_eq("s5_frz_tick", 32'(tick),    32'd0);
      check_eq("s5_frz_clk",  32'(clk_out), 32'd0);
    end
    check_eq("s5_cur_a", 32'(cur_div), 32'd3);
    en = 1'b1;
    // Count resumes from 1: terminal after 3 edges
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check_eq("s5_resume", 32'(tick), (i == 3) ? 32'd1 : 32'd0);
    end
    check_eq("s5_clk_out_a", 32'(clk_out), 32'd1);

    // 5b/5c. sync_clr with en=1 while clk_out=1, count=2: clear wins
    cyc();
    cyc();
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    check_eq("s5_clr_clk",  32'(clk_out), 32'd0);
    check_eq("s5_clr_tick", 32'(tick),    32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_eq("s5_after_clr", 32'(tick), (i == 4) ? 32'd1 : 32'd0);
    end
    check_eq("s5_clk_out_b", 32'(clk_out), 32'd1);

    // 6. Async reset mid-period with a pending load
    div_in   = 8'd9;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    check_eq("s6_pend_a", 32'(pending), 32'd1);
    check_eq("s6_clk_a",  32'(clk_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("s6_rst_clk",  32'(clk_out), 32'd0);
    check_eq("s6_rst_tick", 32'(tick),    32'd0);
    check_eq("s6_rst_cur",  32'(cur_div), 32'd3);
    check_eq("s6_rst_pend", 32'(pending), 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_eq("s6_restart", 32'(tick), (i == 4) ? 32'd1 : 32'd0);
    end
    check_eq("s6_cur_b", 32'(cur_div), 32'd3);

    // Divisor 0: tick every cycle, clk_out toggles every cycle
    en       = 1'b0;
    div_in   = 8'd0;
    div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    en       = 1'b1;
    check_eq("n0_cur", 32'(cur_div), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check_eq("n0_tick", 32'(tick),    32'd1);
      check_eq("n0_clk",  32'(clk_out), ((i % 2) == 1) ? 32'd0 : 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
